ternary_weight_loader: RTL and testbench
========================================

// Module: ternary_weight_loader
// PURPOSE
//  Upstream feeder for the ternary mat-vec multiplier. Receives packed 2-bit ternary weights one byte per
//  handshake, assembles the full 2*InLen*OutLen-bit weight image and holds it stable. Drives the multiplier's
//  enable only while a complete, valid image is present, so W never changes under an active multiply.
// PARAMETERS
//  InLen    16  input-vector length (weight rows)
//  OutLen   8   output-vector length (weight cols)
//  ByteW    8   load-bus width; must divide 2*InLen*OutLen (default 256 bits -> NBytes=32)
// PORTS
//  clk         in   1              system clock
//  rst_n       in   1              async active-low reset
//  load_start  in   1              pulse: begin new weight load
//  in_valid    in   1              in_data holds a weight byte
//  in_data     in   ByteW          4 weights, weight j at bits [2j+1:2j]
//  in_ready    out  1              loader accepts a byte this cycle
//  run         in   1              request multiplier operation
//  W           out  2*InLen*OutLen weight image, weight (row,col) at bits 2*(row*OutLen+col)+:2
//  w_valid     out  1              W complete and stable
//  mult_en     out  1              enable for multiplier = run & w_valid (registered)
//  byte_cnt    out  $clog2(NBytes) bytes accepted in current load
//  code_err    out  1              sticky: an illegal code 2'b10 was received this load
//  checksum    out  ByteW          [WLOAD_CHECKSUM_EN only] XOR of accepted bytes
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; W=0; w_valid=0; mult_en=0; in_ready=0; byte_cnt=0; code_err=0; checksum=0.
//  FSM: IDLE --load_start--> LOAD; LOAD --last byte accepted--> READY; READY --load_start--> LOAD.
//  in_ready = (state==LOAD), combinational from state. Byte accepted on in_valid & in_ready at posedge.
//  Accept: W[byte_cnt*ByteW +: ByteW] <= sanitized in_data; byte_cnt++.
//  Sanitize: each 2-bit field 2'b10 stored as 2'b00 (zero weight) and sets code_err; 00/01/11 stored as is.
//  Accepting byte NBytes-1: byte_cnt wraps to 0; state->READY; w_valid=1 from the next cycle (1-cycle latency).
//  Entering LOAD (from any state): byte_cnt=0, code_err=0, w_valid=0, mult_en=0 on the same edge; W is not
//   cleared (stale bytes overwritten as load proceeds).
//  load_start while in LOAD: restart from byte 0; a byte presented in that same cycle is discarded.
//  load_start in READY with run=1: mult_en drops at the same edge w_valid drops; multiplier sees en=0 and resets.
//  in_valid in IDLE/READY ignored, no state change.
//  mult_en <= run & (state==READY) each cycle; low in IDLE/LOAD regardless of run.
//  Reset mid-load: all state returns to reset values; partial image discarded, w_valid stays 0.
//  W is only written in LOAD; W constant whenever w_valid=1.
// CONFIGURATION
//  WLOAD_CHECKSUM_EN defined: checksum port present; cleared on entering LOAD, checksum ^= raw (unsanitized)
//   in_data per accepted byte; held through READY.
//  WLOAD_CHECKSUM_EN undefined: checksum port and logic absent; all other behaviour identical.
// TESTING
//  1 Reset, load_start, 32 bytes 0x55 back-to-back -> W=all 01, w_valid=1 one cycle after byte 31, code_err=0.
//  2 In READY, run=1 -> mult_en=1 next edge; run=0 -> mult_en=0 next edge; run=1 in LOAD -> mult_en stays 0.
//  3 Load with byte 5=0xA6 (codes 10,01,10,10) -> W[47:40]=0x04, code_err=1; next load_start clears code_err.
//  4 Mid-load (byte_cnt=10) load_start with in_valid=1 -> byte dropped, byte_cnt=0, 32 more bytes to w_valid.
//  5 Assert rst_n=0 at byte_cnt=20 -> W=0, w_valid=0, state IDLE; in_valid bytes ignored until load_start.
//  6 WLOAD_CHECKSUM_EN: load bytes 0..31 (value=index) -> checksum=0x00; 31 bytes of 0xFF plus 0x0F -> 0xF0.

Source files
------------

// File: rtl/ternary_weight_loader.sv
// Ternary weight loader: assembles a 2-bit/weight image from byte loads and gates the multiplier enable.
// Latency: w_valid one cycle after the last byte; mult_en registered. Backpressure: in_ready only in LOAD.
// Optional feature macro WLOAD_CHECKSUM_EN adds a running XOR of raw accepted bytes on the checksum port.
module ternary_weight_loader #(
    parameter  int InLen  = 16,
    parameter  int OutLen = 8,
    parameter  int ByteW  = 8,
    localparam int WW     = 2 * InLen * OutLen,
    localparam int NBytes = WW / ByteW,
    localparam int CntW   = (NBytes > 1) ? $clog2(NBytes) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [ByteW-1:0]  in_data,
    output logic              in_ready,
    input  logic              run,
    output logic [WW-1:0]     W,
    output logic              w_valid,
    output logic              mult_en,
    output logic [CntW-1:0]   byte_cnt,
`ifdef WLOAD_CHECKSUM_EN
    output logic [ByteW-1:0]  checksum,
`endif
    output logic              code_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WW-1:0]     w_q, w_d;
    logic              w_valid_q, w_valid_d;
    logic              mult_en_q, mult_en_d;
    logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
    logic              code_err_q, code_err_d;
    logic              accept;

    // Code 2'b10 has no ternary meaning; it is stored as a zero weight.
    function automatic logic [ByteW-1:0] sanitize(input logic [ByteW-1:0] d);
        logic [ByteW-1:0] s;
        s = d;
        for (int k = 0; k < ByteW / 2; k++) begin
            if (d[2*k +: 2] == 2'b10) begin
                s[2*k +: 2] = 2'b00;
            end
        end
        return s;
    endfunction

    function automatic logic has_illegal(input logic [ByteW-1:0] d);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < ByteW / 2; k++) begin
            if (d[2*k +: 2] == 2'b10) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign in_ready = (state_q == LOAD);
    assign accept   = in_valid && in_ready && !load_start;

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        w_valid_d  = w_valid_q;
        byte_cnt_d = byte_cnt_q;
        code_err_d = code_err_q;
        mult_en_d  = run && (state_q == READY);

        // load_start wins over any byte presented in the same cycle.
        if (load_start) begin
            state_d    = LOAD;
            w_valid_d  = 1'b0;
            mult_en_d  = 1'b0;
            byte_cnt_d = '0;
            code_err_d = 1'b0;
        end else if (accept) begin
            w_d[byte_cnt_q*ByteW +: ByteW] = sanitize(in_data);
            if (has_illegal(in_data)) begin
                code_err_d = 1'b1;
            end
            if (byte_cnt_q == CntW'(NBytes - 1)) begin
                byte_cnt_d = '0;
                state_d    = READY;
                w_valid_d  = 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            w_q        <= '0;
            w_valid_q  <= 1'b0;
            mult_en_q  <= 1'b0;
            byte_cnt_q <= '0;
            code_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            w_valid_q  <= w_valid_d;
            mult_en_q  <= mult_en_d;
            byte_cnt_q <= byte_cnt_d;
            code_err_q <= code_err_d;
        end
    end

`ifdef WLOAD_CHECKSUM_EN
    logic [ByteW-1:0] checksum_q, checksum_d;

    // Checksum covers the raw bus bytes so upstream can verify what it actually sent.
    always_comb begin
        checksum_d = checksum_q;
        if (load_start) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q ^ in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign W        = w_q;
    assign w_valid  = w_valid_q;
    assign mult_en  = mult_en_q;
    assign byte_cnt = byte_cnt_q;
    assign code_err = code_err_q;

endmodule

// File: tb/tb_ternary_weight_loader.sv
// Bench for ternary_weight_loader: byte-array reference model checked every cycle plus literal spot checks.
module tb_ternary_weight_loader;

    localparam int NB = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load_start = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         run = 1'b0;
    logic         in_ready;
    logic [255:0] W;
    logic         w_valid;
    logic         mult_en;
    logic [4:0]   byte_cnt;
    logic         code_err;
`ifdef WLOAD_CHECKSUM_EN
    logic [7:0]   checksum;
`endif

    int checks = 0;
    int failures = 0;

    ternary_weight_loader dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .run(run), .W(W), .w_valid(w_valid),
        .mult_en(mult_en), .byte_cnt(byte_cnt),
`ifdef WLOAD_CHECKSUM_EN
        .checksum(checksum),
`endif
        .code_err(code_err)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 loading, 2 image ready.
    int         m_phase = 0;
    logic [7:0] m_bytes [NB];
    int         m_cnt = 0;
    bit         m_err = 0, m_val = 0, m_en = 0;
    logic [7:0] m_ck = 8'h00;

    function automatic logic [7:0] clean_byte(input logic [7:0] d, output bit bad);
        logic [7:0] r;
        int w;
        r = 8'h00;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            w = (int'(d) >> (2 * k)) & 3;
            if (w == 2) begin
                bad = 1;
                w = 0;
            end
            r = r | 8'(w << (2 * k));
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit bad;
        logic [7:0] c;
        if (!rst_n) begin
            m_phase = 0; m_cnt = 0; m_err = 0; m_val = 0; m_en = 0; m_ck = 8'h00;
            for (int i = 0; i < NB; i++) m_bytes[i] = 8'h00;
        end else begin
            m_en = run && (m_phase == 2);
            if (load_start) begin
                m_phase = 1; m_cnt = 0; m_err = 0; m_val = 0; m_en = 0; m_ck = 8'h00;
            end else if (m_phase == 1 && in_valid) begin
                c = clean_byte(in_data, bad);
                m_bytes[m_cnt] = c;
                if (bad) m_err = 1;
                m_ck = m_ck ^ in_data;
                m_cnt = m_cnt + 1;
                if (m_cnt == NB) begin
                    m_cnt = 0; m_phase = 2; m_val = 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [255:0] exp_w;
        for (int i = 0; i < NB; i++) exp_w[i*8 +: 8] = m_bytes[i];
        chk("model_W", W, exp_w);
        chk("model_in_ready", 256'(in_ready), 256'(m_phase == 1));
        chk("model_w_valid", 256'(w_valid), 256'(m_val));
        chk("model_mult_en", 256'(mult_en), 256'(m_en));
        chk("model_byte_cnt", 256'(byte_cnt), 256'(m_cnt));
        chk("model_code_err", 256'(code_err), 256'(m_err));
`ifdef WLOAD_CHECKSUM_EN
        chk("model_checksum", 256'(checksum), 256'(m_ck));
`endif
    end

    // Drive one cycle of inputs starting at a negedge, return at the next negedge.
    task automatic cyc(input logic ls, input logic iv, input logic [7:0] d, input logic r);
        load_start = ls; in_valid = iv; in_data = d; run = r;
        @(negedge clk);
        load_start = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        logic [255:0] all01;
        logic [7:0]   b;
        for (int i = 0; i < 128; i++) all01[2*i +: 2] = 2'b01;

        @(negedge clk);
        chk("reset_W", W, 256'h0);
        chk("reset_w_valid", 256'(w_valid), 256'h0);
        chk("reset_in_ready", 256'(in_ready), 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: back-to-back load of 0x55
        cyc(1, 0, 8'h00, 0);
        chk("t1_in_ready", 256'(in_ready), 256'h1);
        for (int i = 0; i < NB - 1; i++) cyc(0, 1, 8'h55, 0);
        chk("t1_not_valid_before_last", 256'(w_valid), 256'h0);
        cyc(0, 1, 8'h55, 0);
        chk("t1_w_valid", 256'(w_valid), 256'h1);
        chk("t1_W_all01", W, all01);
        chk("t1_code_err", 256'(code_err), 256'h0);

        // 2: mult_en follows run in READY only
        cyc(0, 1, 8'hFF, 1);
        chk("t2_mult_en_on", 256'(mult_en), 256'h1);
        chk("t2_W_held", W, all01);
        cyc(0, 0, 8'h00, 0);
        chk("t2_mult_en_off", 256'(mult_en), 256'h0);
        cyc(0, 0, 8'h00, 1);
        cyc(1, 0, 8'h00, 1);
        chk("t2_en_drops_on_load", 256'(mult_en), 256'h0);
        chk("t2_valid_drops_on_load", 256'(w_valid), 256'h0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'h11, 1);
        chk("t2_en_low_in_load", 256'(mult_en), 256'h0);

        // 3: illegal codes, with bubbles
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < NB; i++) begin
            b = (i == 5) ? 8'hA6 : 8'((i * 7 + 3) & 8'h55);
            if (i % 4 == 3) cyc(0, 0, 8'hAA, 0);
            cyc(0, 1, b, 0);
        end
        chk("t3_W_byte5", 256'(W[47:40]), 256'h04);
        chk("t3_code_err", 256'(code_err), 256'h1);
        cyc(1, 0, 8'h00, 0);
        chk("t3_code_err_cleared", 256'(code_err), 256'h0);

        // 4: restart mid-load at byte_cnt=10 with a byte on the bus
        for (int i = 0; i < 10; i++) cyc(0, 1, 8'hC3, 0);
        chk("t4_cnt10", 256'(byte_cnt), 256'd10);
        cyc(1, 1, 8'hEE, 0);
        chk("t4_cnt_restart", 256'(byte_cnt), 256'd0);
        for (int i = 0; i < NB - 1; i++) cyc(0, 1, 8'(i), 0);
        chk("t4_not_valid_at_31", 256'(w_valid), 256'h0);
        cyc(0, 1, 8'h1F, 0);
        chk("t4_valid_after_32", 256'(w_valid), 256'h1);

        // 5: async reset mid-load at byte_cnt=20
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 8'h77, 0);
        chk("t5_cnt20", 256'(byte_cnt), 256'd20);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_W_cleared", W, 256'h0);
        chk("t5_w_valid", 256'(w_valid), 256'h0);
        chk("t5_cnt_cleared", 256'(byte_cnt), 256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'h55, 1);
        chk("t5_idle_ignores", W, 256'h0);
        chk("t5_idle_ready", 256'(in_ready), 256'h0);

`ifdef WLOAD_CHECKSUM_EN
        // 6: checksum over raw bytes
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < NB; i++) cyc(0, 1, 8'(i), 0);
        chk("t6_ck_index", 256'(checksum), 256'h00);
        cyc(1, 0, 8'h00, 0);
        for (int i = 0; i < NB - 1; i++) cyc(0, 1, 8'hFF, 0);
        cyc(0, 1, 8'h0F, 0);
        chk("t6_ck_ff", 256'(checksum), 256'hF0);
        cyc(0, 0, 8'h00, 0);
        chk("t6_ck_held", 256'(checksum), 256'hF0);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
